// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the 3BC program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StBranch,
    StDone
  } pc_state_e;

  typedef enum logic {
    ModeRel,
    ModeAbs
  } branch_mode_e;

endpackage

// File: rtl/pc_branch_sequencer_if.sv
// Decoder/LUT-facing bundle of the PC sequencer; slave is the sequencer side.
interface pc_branch_sequencer_if
  import pc_seq_pkg::*;
();

  logic             start;
  logic             halt;
  logic             branch_rel;
  logic             branch_abs;
  logic             branch_cond;
  logic [IDX_W-1:0] instr_idx;
  logic [PC_W-1:0]  lut_out;
  logic [IDX_W-1:0] lut_index;
  logic [PC_W-1:0]  pc;
  logic             stall;
  logic             done;

  modport master (
    output start, halt, branch_rel, branch_abs, branch_cond, instr_idx, lut_out,
    input  lut_index, pc, stall, done
  );

  modport slave (
    input  start, halt, branch_rel, branch_abs, branch_cond, instr_idx, lut_out,
    output lut_index, pc, stall, done
  );

endinterface

// File: rtl/pc_branch_sequencer.sv
// PC owner for the 3BC core: start/run/halt lifecycle plus two-cycle LUT-resolved branches.
module pc_branch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] StartPc = '0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pc_branch_sequencer_if.slave bus
);

  pc_state_e        state_q;
  branch_mode_e     mode_q;
  logic [PC_W-1:0]  pc_q;
  logic [IDX_W-1:0] lut_index_q;
  logic             done_q;
  logic             taken;

  // Absolute wins when both branch kinds are flagged.
  assign taken = (bus.branch_rel & bus.branch_cond) | bus.branch_abs;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= ModeRel;
      pc_q        <= '0;
      lut_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
            pc_q    <= StartPc;
          end
        end
        StRun: begin
          if (bus.halt) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (taken) begin
            state_q     <= StBranch;
            lut_index_q <= bus.instr_idx;
            mode_q      <= bus.branch_abs ? ModeAbs : ModeRel;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        StBranch: begin
          // LUT value is two's complement; unsigned add gives the modulo-2^PC_W wrap.
          state_q <= StRun;
          pc_q    <= (mode_q == ModeAbs) ? bus.lut_out : pc_q + bus.lut_out;
        end
        StDone: begin
          if (bus.start) begin
            state_q <= StRun;
            pc_q    <= StartPc;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.lut_index = lut_index_q;
  assign bus.done      = done_q;
  assign bus.stall     = (state_q != StRun);

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed-vector bench for pc_branch_sequencer with a small table standing in for the LUT.
module tb_pc_branch_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [9:0] lut [16];

  pc_branch_sequencer_if bus ();

  pc_branch_sequencer #(.StartPc(10'd0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.lut_out = lut[bus.lut_index];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.halt        = 1'b0;
    bus.branch_rel  = 1'b0;
    bus.branch_abs  = 1'b0;
    bus.branch_cond = 1'b0;
    bus.instr_idx   = '0;
  endtask

  // Issue one instruction for a single RUN cycle.
  task automatic issue(input logic h, input logic rel, input logic ab, input logic cond,
                       input logic [3:0] idx);
    bus.halt        = h;
    bus.branch_rel  = rel;
    bus.branch_abs  = ab;
    bus.branch_cond = cond;
    bus.instr_idx   = idx;
    step();
    idle_inputs();
  endtask

  // Absolute jump through table entry idx: BRANCH cycle then target.
  task automatic jump(input logic [3:0] idx);
    issue(1'b0, 1'b0, 1'b1, 1'b0, idx);
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = '0;
    lut[0]  = 10'(-408);
    lut[1]  = 10'd1;
    lut[2]  = 10'd1;
    lut[3]  = 10'd5;
    lut[4]  = 10'd7;
    lut[5]  = 10'd500;
    lut[6]  = 10'd1023;
    lut[7]  = 10'd7;
    lut[8]  = 10'd40;
    lut[9]  = 10'd12;
    lut[10] = 10'd300;

    idle_inputs();
    rst = 1'b1;
    step();
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_stall", 32'(bus.stall), 1);
    check("rst_done", 32'(bus.done), 0);
    check("rst_idx", 32'(bus.lut_index), 0);
    rst = 1'b0;
    step();
    check("idle_stall", 32'(bus.stall), 1);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("run_pc0", 32'(bus.pc), 0);
    check("run_stall", 32'(bus.stall), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", 32'(bus.pc), 32'(i));
      check("seq_stall", 32'(bus.stall), 0);
    end

    jump(4'd5);
    check("jump500", 32'(bus.pc), 500);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    check("br_pc_hold", 32'(bus.pc), 500);
    check("br_stall", 32'(bus.stall), 1);
    check("br_idx", 32'(bus.lut_index), 0);
    step();
    check("rel_neg", 32'(bus.pc), 92);
    check("rel_stall", 32'(bus.stall), 0);

    jump(4'd6);
    check("jump1023", 32'(bus.pc), 1023);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
    check("br_idx1", 32'(bus.lut_index), 1);
    step();
    check("rel_wrap", 32'(bus.pc), 0);

    jump(4'd7);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    check("not_taken_pc", 32'(bus.pc), 8);
    check("not_taken_stall", 32'(bus.stall), 0);

    jump(4'd8);
    check("jump40", 32'(bus.pc), 40);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    check("abs_hold", 32'(bus.pc), 40);
    check("abs_stall", 32'(bus.stall), 1);
    step();
    check("abs_pc", 32'(bus.pc), 1);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
    step();
    check("both_abs", 32'(bus.pc), 5);

    jump(4'd9);
    check("jump12", 32'(bus.pc), 12);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
    check("halt_pc", 32'(bus.pc), 12);
    check("halt_done", 32'(bus.done), 1);
    check("halt_stall", 32'(bus.stall), 1);
    step();
    check("done_hold_pc", 32'(bus.pc), 12);
    check("done_hold", 32'(bus.done), 1);
    bus.start = 1'b1;
    step();
    check("restart_pc", 32'(bus.pc), 0);
    check("restart_done", 32'(bus.done), 0);
    step();
    bus.start = 1'b0;
    check("start_in_run", 32'(bus.pc), 1);

    jump(4'd10);
    check("jump300", 32'(bus.pc), 300);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    check("br300_stall", 32'(bus.stall), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_pc", 32'(bus.pc), 0);
    check("mid_rst_stall", 32'(bus.stall), 1);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_idx", 32'(bus.lut_index), 0);
    step();
    check("no_target_pc", 32'(bus.pc), 0);
    check("no_target_stall", 32'(bus.stall), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
